// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the instruction-fetch and data masters.
// Data wins by default; a saturating streak counter forces an instruction grant.
module sram_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        owner
);

  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state;
  logic [StreakW-1:0] streak;
  logic               reqReg;
  logic               ownerReg;
  logic               streakFull;
  logic               grantData;
  logic               respWindow;

  assign streakFull = (streak == StreakW'(MAX_DATA_STREAK));
  assign grantData  = data_req && !(inst_req && streakFull);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      ownerReg <= 1'b0;
      streak   <= '0;
      reqReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req || inst_req) begin
            ownerReg <= grantData;
            reqReg   <= 1'b1;
            state    <= REQ;
            // Only data grants made against a waiting fetch extend the streak.
            if (grantData && inst_req) begin
              if (!streakFull) streak <= streak + StreakW'(1);
            end else begin
              streak <= '0;
            end
          end
        end
        REQ: begin
          if (addr_ok) begin
            reqReg <= 1'b0;
            state  <= data_ok ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (data_ok) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          reqReg <= 1'b0;
        end
      endcase
    end
  end

  // A response is only honoured once the address phase has been accepted.
  assign respWindow = (state == WAIT) || ((state == REQ) && addr_ok);

  assign inst_addr_ok = (state == REQ) && addr_ok && !ownerReg;
  assign data_addr_ok = (state == REQ) && addr_ok && ownerReg;
  assign inst_data_ok = respWindow && data_ok && !ownerReg;
  assign data_data_ok = respWindow && data_ok && ownerReg;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign req          = reqReg;
  assign owner        = ownerReg;

  always_comb begin
    wr    = 1'b0;
    size  = 2'd2;
    wstrb = '0;
    addr  = inst_addr;
    wdata = '0;
    if (ownerReg) begin
      wr    = data_wr;
      size  = data_size;
      wstrb = data_wstrb;
      addr  = data_addr;
      wdata = data_wdata;
    end
  end

endmodule
